// File: rtl/score_accumulator.sv
// Running game-state accumulator behind the per-note scoring block:
// latches each judged note, keeps song totals and latches the final grade.
module score_accumulator #(
  parameter int SCORE_W = 24,
  parameter int CNT_W   = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   total_note,
  input  logic               hit_valid,
  input  logic [CNT_W-1:0]   base_score,
  input  logic [CNT_W-1:0]   bonus_score,
  input  logic [CNT_W-1:0]   combo_in,
  input  logic [2:0]         level_in,
  output logic [CNT_W-1:0]   last_combo,
  output logic [CNT_W-1:0]   last_base_score,
  output logic [CNT_W-1:0]   now_cnt,
  output logic [SCORE_W-1:0] total_score,
  output logic [CNT_W-1:0]   max_combo,
  output logic [CNT_W-1:0]   miss_cnt,
  output logic               busy,
  output logic               done,
  output logic [2:0]         final_level
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SETTLE, S_DONE} state_t;

  localparam logic [2:0] WORST_LEVEL = 3'd6;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   total_note_q, total_note_d;
  logic [CNT_W-1:0]   now_cnt_q, now_cnt_d;
  logic [CNT_W-1:0]   last_base_q, last_base_d;
  logic [SCORE_W-1:0] total_score_q, total_score_d;
  logic [CNT_W-1:0]   last_combo_q, last_combo_d;
  logic [CNT_W-1:0]   max_combo_q, max_combo_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [2:0]         final_level_q, final_level_d;

  logic [CNT_W-1:0]   now_inc;
  logic [CNT_W:0]     base_sum;
  logic [SCORE_W:0]   score_sum;
  logic [CNT_W:0]     combo_limit;
  logic [CNT_W-1:0]   combo_clean;

  always_comb begin
    now_inc   = now_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    base_sum  = {1'b0, last_base_q} + {1'b0, base_score};
    score_sum = {1'b0, total_score_q}
              + {{(SCORE_W+1-CNT_W){1'b0}}, base_score}
              + {{(SCORE_W+1-CNT_W){1'b0}}, bonus_score};
    // A combo that jumps by more than 2 is an underflow wrap upstream: treat as broken.
    combo_limit = {1'b0, last_combo_q} + {{(CNT_W-1){1'b0}}, 2'd2};
    combo_clean = ({1'b0, combo_in} > combo_limit) ? '0 : combo_in;
  end

  always_comb begin
    state_d       = state_q;
    total_note_d  = total_note_q;
    now_cnt_d     = now_cnt_q;
    last_base_d   = last_base_q;
    total_score_d = total_score_q;
    last_combo_d  = last_combo_q;
    max_combo_d   = max_combo_q;
    miss_cnt_d    = miss_cnt_q;
    final_level_d = final_level_q;

    if (start) begin
      // Start is honoured in every state and drops any same-cycle hit.
      total_note_d  = total_note;
      now_cnt_d     = '0;
      last_base_d   = '0;
      total_score_d = '0;
      last_combo_d  = '0;
      max_combo_d   = '0;
      miss_cnt_d    = '0;
      final_level_d = WORST_LEVEL;
      state_d       = (total_note != '0) ? S_PLAY : S_DONE;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (hit_valid) begin
            now_cnt_d     = now_inc;
            last_base_d   = base_sum[CNT_W] ? '1 : base_sum[CNT_W-1:0];
            total_score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            last_combo_d  = combo_clean;
            if (combo_clean > max_combo_q) max_combo_d = combo_clean;
            if (base_score == '0) miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (now_inc == total_note_q) state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          final_level_d = level_in;
          state_d       = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      total_note_q  <= '0;
      now_cnt_q     <= '0;
      last_base_q   <= '0;
      total_score_q <= '0;
      last_combo_q  <= '0;
      max_combo_q   <= '0;
      miss_cnt_q    <= '0;
      final_level_q <= WORST_LEVEL;
    end else begin
      state_q       <= state_d;
      total_note_q  <= total_note_d;
      now_cnt_q     <= now_cnt_d;
      last_base_q   <= last_base_d;
      total_score_q <= total_score_d;
      last_combo_q  <= last_combo_d;
      max_combo_q   <= max_combo_d;
      miss_cnt_q    <= miss_cnt_d;
      final_level_q <= final_level_d;
    end
  end

  assign last_combo      = last_combo_q;
  assign last_base_score = last_base_q;
  assign now_cnt         = now_cnt_q;
  assign total_score     = total_score_q;
  assign max_combo       = max_combo_q;
  assign miss_cnt        = miss_cnt_q;
  assign busy            = (state_q == S_PLAY) || (state_q == S_SETTLE);
  assign done            = (state_q == S_DONE);
  assign final_level     = final_level_q;

endmodule

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
- Sequential stage directly downstream of the per-note scoring block; holds all running game state.
- On every judged note it latches that block's combinational results (base score, bonus score, new combo) and accumulates the song totals.
- Feeds back last_combo, last_base_score and now_cnt to the scoring block.
- At song end it latches the final grade level and raises done for the result display.

Parameters:
SCORE_W, 24, width of total_score (saturating)
CNT_W, 21, width of counters, combo and base-score accumulators (matches the scoring block's 21-bit buses)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin a new song, clears all state
total_note  in  CNT_W  note count of the song; sampled on start
hit_valid  in  1  one-cycle pulse: scoring-block outputs are valid for the current note
base_score  in  CNT_W  base score of the current note
bonus_score  in  CNT_W  bonus score of the current note
combo_in  in  CNT_W  new combo computed by the scoring block
level_in  in  3  grade level from the scoring block (0 best .. 6 worst)
last_combo  out  CNT_W  registered combo, fed back to the scoring block
last_base_score  out  CNT_W  running sum of base_score, fed back
now_cnt  out  CNT_W  notes judged so far
total_score  out  SCORE_W  running base+bonus sum
max_combo  out  CNT_W  highest combo reached
miss_cnt  out  CNT_W  notes with base_score == 0
busy  out  1  high in PLAY and SETTLE
done  out  1  high in DONE
final_level  out  3  grade latched at song end

Behaviour:
- Reset: state=IDLE; all counters, accumulators and last_combo = 0; busy=0; done=0; final_level=6.
- FSM states: IDLE, PLAY, SETTLE, DONE.
- IDLE:
  - start with total_note != 0 -> clear all accumulators, latch total_note, go to PLAY.
  - start with total_note == 0 -> clear all, final_level=6, go to DONE.
- PLAY, on hit_valid (registered, 1-cycle latency; outputs update the cycle after the pulse):
  - now_cnt += 1.
  - last_base_score += base_score; saturates at 2^CNT_W-1.
  - total_score += base_score + bonus_score; computed at SCORE_W+1 bits, saturates at 2^SCORE_W-1.
  - Combo sanitising: if combo_in > last_combo+2 (underflow wrap in the scoring block), store 0; else store combo_in.
  - max_combo = max(max_combo, stored combo).
  - miss_cnt += 1 when base_score == 0.
  - Transition: if the post-increment now_cnt == latched total_note -> SETTLE.
  - hit_valid is ignored outside PLAY, including extra pulses after the last note.
- SETTLE: exactly one cycle, which lets level_in settle on the final fed-back values. Latch final_level = level_in, then go to DONE.
- DONE:
  - done=1; all outputs hold.
  - start restarts exactly as from IDLE (clear, then PLAY, or DONE if total_note==0).
- Simultaneous events:
  - start in PLAY or SETTLE aborts the song: clear and restart. start wins over a same-cycle hit_valid, whose hit is dropped.
  - rst wins over everything.
- Reset mid-song returns to IDLE with the reset values above; no partial totals survive.
- No combinational path from any input to any output.

Test Plan:
1. rst, start total_note=3, three hit_valid with base=300/bonus=32/combo_in=1,2,3 -> now_cnt=3, last_base_score=900, total_score=996, max_combo=3, miss_cnt=0; SETTLE one cycle; level_in=2 -> final_level=2, done=1.
2. last_combo=5, hit with combo_in=0x1FFFF0 (wrapped) -> last_combo=0, max_combo stays 5.
3. Miss handling: base=0/bonus=0/combo_in=0 on note 2 of 4 -> miss_cnt=1, last_combo=0, max_combo keeps its earlier value; song completes at now_cnt=4.
4. Saturation: preload via 200 hits of base=bonus=2^20 with SCORE_W=24 -> total_score sticks at 0xFFFFFF; last_base_score sticks at 0x1FFFFF.
5. start total_note=0 -> DONE next cycle, final_level=6, now_cnt=0; extra hit_valid pulses in DONE change nothing.
6. start and hit_valid in the same cycle mid-song, then rst mid-song -> first: counters cleared and hit dropped; second: state IDLE, all outputs at reset values, busy=0.
